// File: rtl/wb_sram_ctrl_if.sv
// Wishbone classic bus bundle between the m68k bridge (master) and
// wb_sram_ctrl (slave). Signal names follow the slave's view of the bus.
interface wb_sram_ctrl_if;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_I;
  logic        WE_I;
  logic        STB_I;
  logic        CYC_I;
  logic        ACK_O;
  logic        ERR_O;

  modport master (
    output ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
    input  DAT_O, ACK_O, ERR_O
  );

  modport slave (
    input  ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
    output DAT_O, ACK_O, ERR_O
  );
endinterface

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving an asynchronous 32-bit SRAM with a
// programmable number of wait states. Every output is registered.
// Optional feature macro: WB_SRAM_ERR_EN -- requests with non-zero address
// bits above the SRAM window terminate with ERR_O instead of aliasing.
module wb_sram_ctrl #(
  parameter int unsigned AB_WIDTH    = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  wb_sram_ctrl_if.slave       wb,
  output logic [AB_WIDTH-1:0] sram_addr_o,
  output logic [31:0]         sram_dat_o,
  input  logic [31:0]         sram_dat_i,
  output logic [3:0]          sram_bsel_o,
  output logic                sram_ncs_o,
  output logic                sram_noe_o,
  output logic                sram_nwe_o
);

`ifdef WB_SRAM_ERR_EN
  typedef enum logic [1:0] {StIdle, StAccess, StDone, StError} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
`endif

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);
  // With no wait states the first ACCESS cycle is already the final one.
  localparam bit ZeroWait = (WAIT_CYCLES == 0);

  state_e              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [AB_WIDTH-1:0] r_addr;
  logic [31:0]         r_wdat;
  logic [3:0]          r_bsel;
  logic                r_ncs;
  logic                r_noe;
  logic                r_nwe;
  logic                r_ack;
  logic [31:0]         r_dat_o;

  logic w_req;
  logic w_unused;

  assign w_req    = wb.CYC_I & wb.STB_I;
  // Byte-lane bits and (when not range-checked) upper bits are don't-care.
  assign w_unused = ^{wb.ADR_I[31:AB_WIDTH+2], wb.ADR_I[1:0]};

`ifdef WB_SRAM_ERR_EN
  logic r_err;
  logic w_addr_hi_bad;
  assign w_addr_hi_bad = |wb.ADR_I[31:AB_WIDTH+2];
  assign wb.ERR_O      = r_err;
`else
  assign wb.ERR_O      = 1'b0;
`endif

  assign wb.ACK_O    = r_ack;
  assign wb.DAT_O    = r_dat_o;
  assign sram_addr_o = r_addr;
  assign sram_dat_o  = r_wdat;
  assign sram_bsel_o = r_bsel;
  assign sram_ncs_o  = r_ncs;
  assign sram_noe_o  = r_noe;
  assign sram_nwe_o  = r_nwe;

  // Access sequencer: latches the request, times the SRAM strobes, acks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_bsel  <= '0;
      r_ncs   <= 1'b1;
      r_noe   <= 1'b1;
      r_nwe   <= 1'b1;
      r_ack   <= 1'b0;
      r_dat_o <= '0;
`ifdef WB_SRAM_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
`ifdef WB_SRAM_ERR_EN
            if (w_addr_hi_bad) begin
              r_err   <= 1'b1;
              r_state <= StError;
            end else begin
`endif
              r_addr  <= wb.ADR_I[AB_WIDTH+1:2];
              r_bsel  <= wb.SEL_I;
              r_wdat  <= wb.DAT_I;
              r_we    <= wb.WE_I;
              r_cnt   <= WaitInit;
              r_ncs   <= 1'b0;
              r_noe   <= wb.WE_I;
              r_nwe   <= ~(wb.WE_I & ZeroWait);
              r_state <= StAccess;
`ifdef WB_SRAM_ERR_EN
            end
`endif
          end
        end

        StAccess: begin
          if (!w_req) begin
            // Abort takes priority over completion: no ack, no data capture.
            r_ncs   <= 1'b1;
            r_noe   <= 1'b1;
            r_nwe   <= 1'b1;
            r_bsel  <= '0;
            r_state <= StIdle;
          end else if (r_cnt == 4'd0) begin
            if (!r_we) begin
              r_dat_o <= sram_dat_i;
            end
            r_ncs   <= 1'b1;
            r_noe   <= 1'b1;
            r_nwe   <= 1'b1;
            r_bsel  <= '0;
            r_ack   <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            // Pull nwe low only for the final cycle so the SRAM commits once.
            r_nwe <= ~(r_we & (r_cnt == 4'd1));
          end
        end

        StDone: begin
          r_ack   <= 1'b0;
          r_state <= StIdle;
        end

`ifdef WB_SRAM_ERR_EN
        StError: begin
          r_err   <= 1'b0;
          r_state <= StIdle;
        end
`endif

        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Self-checking bench for wb_sram_ctrl with a behavioural async SRAM model,
// a reference memory and a queue of expected read data.
module tb_wb_sram_ctrl;
  localparam int unsigned AbWidth = 18;
  localparam int unsigned W       = 1;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  wb_sram_ctrl_if wb ();

  logic [AbWidth-1:0] sram_addr_o;
  logic [31:0]        sram_dat_o;
  logic [31:0]        sram_dat_i;
  logic [3:0]         sram_bsel_o;
  logic               sram_ncs_o;
  logic               sram_noe_o;
  logic               sram_nwe_o;

  wb_sram_ctrl #(
    .AB_WIDTH   (AbWidth),
    .WAIT_CYCLES(W)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wb         (wb),
    .sram_addr_o(sram_addr_o),
    .sram_dat_o (sram_dat_o),
    .sram_dat_i (sram_dat_i),
    .sram_bsel_o(sram_bsel_o),
    .sram_ncs_o (sram_ncs_o),
    .sram_noe_o (sram_noe_o),
    .sram_nwe_o (sram_nwe_o)
  );

  always #5 clk_i = ~clk_i;

  // Async SRAM model: small window, drives a junk pattern when not enabled.
  logic [31:0] sram [0:1023];
  assign sram_dat_i = (!sram_ncs_o && !sram_noe_o) ? sram[sram_addr_o[9:0]] : 32'hBAD0_BAD0;
  always @(posedge clk_i) begin
    if (!sram_ncs_o && !sram_nwe_o) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_bsel_o[b]) sram[sram_addr_o[9:0]][8*b +: 8] <= sram_dat_o[8*b +: 8];
      end
    end
  end

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  // Strobe activity monitor, sampled mid-cycle.
  int                 nwe_low_total       = 0;
  int                 noe_low_total       = 0;
  int                 ncs_low_total       = 0;
  int                 addr_unstable_total = 0;
  logic [AbWidth-1:0] last_acc_addr       = '0;
  logic               prev_ncs_low        = 1'b0;
  always @(negedge clk_i) begin
    if (!sram_nwe_o) nwe_low_total++;
    if (!sram_noe_o) noe_low_total++;
    if (!sram_ncs_o) begin
      ncs_low_total++;
      if (prev_ncs_low && sram_addr_o !== last_acc_addr) addr_unstable_total++;
      last_acc_addr = sram_addr_o;
    end
    prev_ncs_low = !sram_ncs_o;
  end

  int          checks   = 0;
  int          failures = 0;
  int          t_req    = 0;
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_q [$];

  task automatic ref_write(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) ref_mem[adr[11:2]][8*b +: 8] = dat[8*b +: 8];
    end
  endtask

  task automatic bus_req(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we);
    @(posedge clk_i);
    #1;
    wb.ADR_I = adr;
    wb.DAT_I = dat;
    wb.SEL_I = sel;
    wb.WE_I  = we;
    wb.CYC_I = 1'b1;
    wb.STB_I = 1'b1;
    t_req    = cyc_cnt;
  endtask

  task automatic bus_drop();
    @(posedge clk_i);
    #1;
    wb.CYC_I = 1'b0;
    wb.STB_I = 1'b0;
    wb.WE_I  = 1'b0;
  endtask

  task automatic wait_resp(output bit got_ack, output bit got_err, output int at);
    got_ack = 1'b0;
    got_err = 1'b0;
    at      = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (wb.ACK_O) begin
        got_ack = 1'b1;
        at      = cyc_cnt;
        break;
      end
      if (wb.ERR_O) begin
        got_err = 1'b1;
        at      = cyc_cnt;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({wb.ACK_O, wb.ERR_O, sram_ncs_o, sram_noe_o, sram_nwe_o} !== 5'b00111) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 00111",
               {wb.ACK_O, wb.ERR_O, sram_ncs_o, sram_noe_o, sram_nwe_o});
    end
    checks++;
    if (wb.DAT_O !== 32'h0 || sram_dat_o !== 32'h0 || sram_addr_o !== '0 || sram_bsel_o !== 4'h0)
    begin
      failures++;
      $display("FAIL reset_data: got dat_o=%h sdat=%h addr=%h bsel=%h want all zero",
               wb.DAT_O, sram_dat_o, sram_addr_o, sram_bsel_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_write_read();
    bit ack, err;
    int at, nwe0, noe0, us0;
    logic [31:0] exp;
    nwe0 = nwe_low_total;
    noe0 = noe_low_total;
    us0  = addr_unstable_total;
    bus_req(32'h400, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wait_resp(ack, err, at);
    checks++;
    if (!ack || at - t_req != int'(W) + 2) begin
      failures++;
      $display("FAIL wr_ack_latency: got ack=%0b lat=%0d want ack=1 lat=%0d", ack, at - t_req, W + 2);
    end
    checks++;
    if (nwe_low_total - nwe0 != 1) begin
      failures++;
      $display("FAIL wr_nwe_cycles: got %0d want 1", nwe_low_total - nwe0);
    end
    checks++;
    if (noe_low_total - noe0 != 0) begin
      failures++;
      $display("FAIL wr_noe_low: got %0d want 0", noe_low_total - noe0);
    end
    checks++;
    if (last_acc_addr !== 18'h100 || addr_unstable_total != us0) begin
      failures++;
      $display("FAIL wr_sram_addr: got %h unstable=%0d want 100 unstable=0",
               last_acc_addr, addr_unstable_total - us0);
    end
    bus_drop();
    ref_write(32'h400, 32'hDEAD_BEEF, 4'hF);

    exp_q.push_back(ref_mem[10'h100]);
    nwe0 = nwe_low_total;
    bus_req(32'h400, 32'h0, 4'hF, 1'b0);
    wait_resp(ack, err, at);
    exp = exp_q.pop_front();
    checks++;
    if (!ack || at - t_req != int'(W) + 2 || wb.DAT_O !== exp) begin
      failures++;
      $display("FAIL rd_data: got ack=%0b lat=%0d dat=%h want ack=1 lat=%0d dat=%h",
               ack, at - t_req, wb.DAT_O, W + 2, exp);
    end
    checks++;
    if (nwe_low_total != nwe0) begin
      failures++;
      $display("FAIL rd_nwe_low: got %0d want 0", nwe_low_total - nwe0);
    end
    bus_drop();
  endtask

  task automatic test_byte_write();
    bit ack, err;
    int at;
    logic [31:0] exp;
    bus_req(32'h400, 32'h0000_AB00, 4'b0010, 1'b1);
    wait_resp(ack, err, at);
    checks++;
    if (!ack) begin
      failures++;
      $display("FAIL bw_ack: got 0 want 1");
    end
    bus_drop();
    ref_write(32'h400, 32'h0000_AB00, 4'b0010);
    exp_q.push_back(32'hDEAD_ABEF);
    bus_req(32'h400, 32'h0, 4'hF, 1'b0);
    wait_resp(ack, err, at);
    exp = exp_q.pop_front();
    checks++;
    if (!ack || wb.DAT_O !== exp) begin
      failures++;
      $display("FAIL bw_read: got ack=%0b dat=%h want ack=1 dat=%h", ack, wb.DAT_O, exp);
    end
    bus_drop();
  endtask

  task automatic test_abort();
    bit ack, err, ack_seen;
    int at, nwe0;
    logic [31:0] exp;
    bus_req(32'h800, 32'h1234_5678, 4'hF, 1'b1);
    wait_resp(ack, err, at);
    bus_drop();
    ref_write(32'h800, 32'h1234_5678, 4'hF);

    nwe0 = nwe_low_total;
    bus_req(32'h800, 32'hCAFE_F00D, 4'hF, 1'b1);
    @(posedge clk_i);
    #1;
    wb.CYC_I = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (wb.ACK_O) ack_seen = 1'b1;
    end
    wb.STB_I = 1'b0;
    wb.WE_I  = 1'b0;
    checks++;
    if (ack_seen || nwe_low_total != nwe0 || sram_ncs_o !== 1'b1) begin
      failures++;
      $display("FAIL abort: got ack=%0b nwe_cycles=%0d ncs=%b want ack=0 nwe_cycles=0 ncs=1",
               ack_seen, nwe_low_total - nwe0, sram_ncs_o);
    end
    exp_q.push_back(ref_mem[10'h200]);
    bus_req(32'h800, 32'h0, 4'hF, 1'b0);
    wait_resp(ack, err, at);
    exp = exp_q.pop_front();
    checks++;
    if (!ack || wb.DAT_O !== exp) begin
      failures++;
      $display("FAIL abort_readback: got ack=%0b dat=%h want ack=1 dat=%h", ack, wb.DAT_O, exp);
    end
    bus_drop();
  endtask

  task automatic test_back_to_back();
    bit ack, err;
    int a1, a2;
    logic [31:0] exp;
    bus_req(32'h404, 32'h0BAD_F00D, 4'hF, 1'b1);
    wait_resp(ack, err, a1);
    bus_drop();
    ref_write(32'h404, 32'h0BAD_F00D, 4'hF);

    exp_q.push_back(ref_mem[10'h100]);
    exp_q.push_back(ref_mem[10'h101]);
    bus_req(32'h400, 32'h0, 4'hF, 1'b0);
    wait_resp(ack, err, a1);
    exp = exp_q.pop_front();
    checks++;
    if (!ack || wb.DAT_O !== exp) begin
      failures++;
      $display("FAIL b2b_first: got ack=%0b dat=%h want ack=1 dat=%h", ack, wb.DAT_O, exp);
    end
    @(posedge clk_i);
    #1;
    wb.ADR_I = 32'h404;
    wait_resp(ack, err, a2);
    exp = exp_q.pop_front();
    checks++;
    if (!ack || wb.DAT_O !== exp) begin
      failures++;
      $display("FAIL b2b_second: got ack=%0b dat=%h want ack=1 dat=%h", ack, wb.DAT_O, exp);
    end
    checks++;
    if (a2 - a1 != int'(W) + 3) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d want %0d", a2 - a1, W + 3);
    end
    bus_drop();
  endtask

  task automatic test_addr_range();
    bit ack, err;
    int at, ncs0;
    bus_req(32'h0, 32'h55AA_55AA, 4'hF, 1'b1);
    wait_resp(ack, err, at);
    bus_drop();
    ref_write(32'h0, 32'h55AA_55AA, 4'hF);

    ncs0 = ncs_low_total;
`ifdef WB_SRAM_ERR_EN
    bus_req(32'h0100_0000, 32'h0, 4'hF, 1'b0);
    wait_resp(ack, err, at);
    checks++;
    if (!err || ack || ncs_low_total != ncs0) begin
      failures++;
      $display("FAIL range_err: got err=%0b ack=%0b ncs_cycles=%0d want err=1 ack=0 ncs_cycles=0",
               err, ack, ncs_low_total - ncs0);
    end
    bus_drop();
    @(negedge clk_i);
    checks++;
    if (wb.ERR_O !== 1'b0) begin
      failures++;
      $display("FAIL range_err_width: got %b want 0", wb.ERR_O);
    end
`else
    exp_q.push_back(ref_mem[10'h0]);
    bus_req(32'h0100_0000, 32'h0, 4'hF, 1'b0);
    wait_resp(ack, err, at);
    begin
      logic [31:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (!ack || err || wb.DAT_O !== exp || ncs_low_total == ncs0) begin
        failures++;
        $display("FAIL range_alias: got ack=%0b err=%0b dat=%h want ack=1 err=0 dat=%h",
                 ack, err, wb.DAT_O, exp);
      end
    end
    bus_drop();
`endif
  endtask

  task automatic test_reset_mid();
    bit ack, err;
    int at;
    logic [31:0] exp;
    bus_req(32'h400, 32'h0, 4'hF, 1'b0);
    @(posedge clk_i);
    #2;
    checks++;
    if (sram_ncs_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_active: got ncs=%b want 0", sram_ncs_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({sram_ncs_o, sram_noe_o, sram_nwe_o, wb.ACK_O} !== 4'b1110 || wb.DAT_O !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_force: got ctrl=%b dat=%h want ctrl=1110 dat=0",
               {sram_ncs_o, sram_noe_o, sram_nwe_o, wb.ACK_O}, wb.DAT_O);
    end
    wb.CYC_I = 1'b0;
    wb.STB_I = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    bus_req(32'h40C, 32'hA5A5_5A5A, 4'hF, 1'b1);
    wait_resp(ack, err, at);
    checks++;
    if (!ack || at - t_req != int'(W) + 2) begin
      failures++;
      $display("FAIL rst_after_write: got ack=%0b lat=%0d want ack=1 lat=%0d", ack, at - t_req, W + 2);
    end
    bus_drop();
    ref_write(32'h40C, 32'hA5A5_5A5A, 4'hF);
    exp_q.push_back(ref_mem[10'h103]);
    bus_req(32'h40C, 32'h0, 4'hF, 1'b0);
    wait_resp(ack, err, at);
    exp = exp_q.pop_front();
    checks++;
    if (!ack || wb.DAT_O !== exp) begin
      failures++;
      $display("FAIL rst_after_read: got ack=%0b dat=%h want ack=1 dat=%h", ack, wb.DAT_O, exp);
    end
    bus_drop();
  endtask

  initial begin
    wb.ADR_I = '0;
    wb.DAT_I = '0;
    wb.SEL_I = '0;
    wb.WE_I  = 1'b0;
    wb.STB_I = 1'b0;
    wb.CYC_I = 1'b0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_abort();
    test_back_to_back();
    test_addr_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
